// File: rtl/riscv_issue_ctrl.sv
// riscv_issue_ctrl: one-entry issue buffer in front of riscv_exec with RAW
// forwarding (or a one-cycle stall), writeback of the exec result, branch
// redirect/flush and a sticky illegal-instruction fault latch.
module riscv_issue_ctrl #(
  parameter logic FWD_EN  = 1'b1,
  parameter int   COUNT_W = 32
) (
  input  logic               InClk,
  input  logic               InRstN,
  input  logic               InFetchValid,
  input  logic [31:0]        InFetchOpcode,
  input  logic [31:0]        InFetchPc,
  input  logic               InFetchInvalid,
  input  logic [4:0]         InFetchRdIdx,
  input  logic [4:0]         InFetchRaIdx,
  input  logic [4:0]         InFetchRbIdx,
  output logic               OutFetchAccept,
  output logic               OutFetchRedirect,
  output logic [31:0]        OutFetchRedirectPc,
  input  logic               InStall,
  output logic [4:0]         OutRfRaIdx,
  output logic [4:0]         OutRfRbIdx,
  input  logic [31:0]        InRfRaValue,
  input  logic [31:0]        InRfRbValue,
  output logic               OutRfWrEn,
  output logic [4:0]         OutRfWrIdx,
  output logic [31:0]        OutRfWrData,
  output logic               OutExecValid,
  output logic [31:0]        OutExecOpcode,
  output logic [31:0]        OutExecPc,
  output logic               OutExecInvalid,
  output logic [4:0]         OutExecRdIdx,
  output logic [4:0]         OutExecRaIdx,
  output logic [4:0]         OutExecRbIdx,
  output logic [31:0]        OutExecRaOperand,
  output logic [31:0]        OutExecRbOperand,
  output logic               OutExecHold,
  input  logic [31:0]        InExecWbValue,
  input  logic               InBranchRequest,
  input  logic               InBranchIsTaken,
  input  logic [31:0]        InBranchPc,
  output logic               OutFault,
  output logic [31:0]        OutFaultPc,
  output logic [COUNT_W-1:0] OutIssueCount
);

  typedef enum logic [1:0] {ST_RUN, ST_BR_WAIT, ST_FAULT} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_buf_valid, r_buf_inv;
  logic [31:0]         r_buf_op, r_buf_pc;
  logic [4:0]          r_buf_rd, r_buf_ra, r_buf_rb;
  logic                r_pend_valid;
  logic [4:0]          r_pend_rd;
  logic                r_fault;
  logic [31:0]         r_fault_pc;
  logic [COUNT_W-1:0]  r_cnt;

  logic w_run, w_is_ctrl, w_dep_a, w_dep_b, w_raw_stall, w_issue, w_accept;
  logic w_take, w_br_taken, w_fault_hit, w_pend_live;
  logic [31:0] w_ra_op, w_rb_op;

  assign w_run       = (r_state == ST_RUN);
  assign w_is_ctrl   = (r_buf_op[6:0] == 7'b1101111) | (r_buf_op[6:0] == 7'b1100111) |
                       (r_buf_op[6:0] == 7'b1100011);
  // x0 is never a real producer, so it never forwards or stalls
  assign w_pend_live = r_pend_valid & (r_pend_rd != 5'd0);
  assign w_dep_a     = w_pend_live & (r_buf_ra == r_pend_rd);
  assign w_dep_b     = w_pend_live & (r_buf_rb == r_pend_rd);
  assign w_raw_stall = ~FWD_EN & (w_dep_a | w_dep_b);
  assign w_issue     = w_run & r_buf_valid & ~r_buf_inv & ~InStall & ~w_raw_stall;
  // accept is held low while reset is asserted so the fetch side sees an idle port
  assign w_accept    = InRstN & w_run & (~r_buf_valid | w_issue);
  assign w_take      = w_accept & InFetchValid;
  assign w_br_taken  = (r_state == ST_BR_WAIT) & InBranchRequest & InBranchIsTaken;
  assign w_fault_hit = w_run & r_buf_valid & r_buf_inv;

  assign w_ra_op = (FWD_EN & w_dep_a) ? InExecWbValue : InRfRaValue;
  assign w_rb_op = (FWD_EN & w_dep_b) ? InExecWbValue : InRfRbValue;

  assign OutFetchAccept     = w_accept;
  assign OutFetchRedirect   = w_br_taken;
  assign OutFetchRedirectPc = w_br_taken ? InBranchPc : 32'd0;
  assign OutRfRaIdx         = r_buf_ra;
  assign OutRfRbIdx         = r_buf_rb;
  assign OutRfWrEn          = w_pend_live;
  assign OutRfWrIdx         = r_pend_rd;
  assign OutRfWrData        = r_pend_valid ? InExecWbValue : 32'd0;
  assign OutExecValid       = w_issue;
  assign OutExecHold        = ~w_issue;
  assign OutExecOpcode      = r_buf_op;
  assign OutExecPc          = r_buf_pc;
  assign OutExecInvalid     = 1'b0;
  assign OutExecRdIdx       = r_buf_rd;
  assign OutExecRaIdx       = r_buf_ra;
  assign OutExecRbIdx       = r_buf_rb;
  assign OutExecRaOperand   = r_buf_valid ? w_ra_op : 32'd0;
  assign OutExecRbOperand   = r_buf_valid ? w_rb_op : 32'd0;
  assign OutFault           = r_fault;
  assign OutFaultPc         = r_fault_pc;
  assign OutIssueCount      = r_cnt;

  // state register
  always_ff @(posedge InClk or negedge InRstN) begin
    if (!InRstN) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  // next state: fault at head wins over everything, control ops wait one cycle for the outcome
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_fault_hit)             w_state_nxt = ST_FAULT;
        else if (w_issue & w_is_ctrl) w_state_nxt = ST_BR_WAIT;
      end
      ST_BR_WAIT: w_state_nxt = ST_RUN;
      ST_FAULT:   w_state_nxt = ST_FAULT;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // issue buffer: taken branch drops the wrong-path entry, else load on take, drain on issue
  always_ff @(posedge InClk or negedge InRstN) begin
    if (!InRstN) begin
      r_buf_valid <= 1'b0;
      r_buf_inv   <= 1'b0;
      r_buf_op    <= 32'd0;
      r_buf_pc    <= 32'd0;
      r_buf_rd    <= 5'd0;
      r_buf_ra    <= 5'd0;
      r_buf_rb    <= 5'd0;
    end else if (w_br_taken) begin
      r_buf_valid <= 1'b0;
    end else if (w_take) begin
      r_buf_valid <= 1'b1;
      r_buf_inv   <= InFetchInvalid;
      r_buf_op    <= InFetchOpcode;
      r_buf_pc    <= InFetchPc;
      r_buf_rd    <= InFetchRdIdx;
      r_buf_ra    <= InFetchRaIdx;
      r_buf_rb    <= InFetchRbIdx;
    end else if (w_issue) begin
      r_buf_valid <= 1'b0;
    end
  end

  // pending writeback tracks the single instruction whose result arrives next cycle
  always_ff @(posedge InClk or negedge InRstN) begin
    if (!InRstN) begin
      r_pend_valid <= 1'b0;
      r_pend_rd    <= 5'd0;
    end else begin
      r_pend_valid <= w_issue;
      if (w_issue) r_pend_rd <= r_buf_rd;
    end
  end

  // sticky fault latch and wrapping issue counter
  always_ff @(posedge InClk or negedge InRstN) begin
    if (!InRstN) begin
      r_fault    <= 1'b0;
      r_fault_pc <= 32'd0;
      r_cnt      <= '0;
    end else begin
      if (w_fault_hit) begin
        r_fault    <= 1'b1;
        r_fault_pc <= r_buf_pc;
      end
      if (w_issue) r_cnt <= r_cnt + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_riscv_issue_ctrl.sv
// tb_riscv_issue_ctrl: drives a forwarding and a stalling instance side by side
// from a small fetch/exec/regfile environment and checks both against an
// instruction-level model every cycle, plus directed program scenarios.
module tb_riscv_issue_ctrl;

  typedef struct packed {
    logic [31:0] op;
    logic [31:0] pc;
    logic        inv;
    logic [4:0]  rd, ra, rb;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc_no = 0;

  // per-instance DUT connections, index 0 = forwarding, 1 = stalling
  logic        fv[2], finv[2], stall[2], brq[2], brt[2];
  logic [31:0] f_op[2], f_pc[2], rfa[2], rfb[2], wbv[2], brpc[2];
  logic [4:0]  f_rd[2], f_ra[2], f_rb[2];
  logic        o_acc[2], o_red[2], o_we[2], o_ev[2], o_einv[2], o_hold[2], o_flt[2];
  logic [31:0] o_redpc[2], o_wdat[2], o_eop[2], o_epc[2], o_opa[2], o_opb[2], o_fpc[2], o_cnt[2];
  logic [4:0]  o_rfra[2], o_rfrb[2], o_widx[2], o_erd[2], o_era[2], o_erb[2];

  // environment state
  logic [31:0] env_rf [2][32];
  logic [31:0] mem [256];
  logic        minv [256];
  logic [31:0] prog_lo, prog_hi, start_pc;
  int          smode, vpct;
  logic [31:0] fetch_pc[2];
  int          n_iss[2], n_red[2];
  int          c_iss[2][8];
  logic [31:0] p_iss[2][8];
  logic [31:0] red_pc[2];

  // reference model state
  ins_t        mq[2][$];
  int          ms[2];           // 0 running, 1 awaiting branch outcome, 2 faulted
  logic        pv[2];
  logic [4:0]  prd[2];
  logic [31:0] pval[2];
  logic        brt_m[2];
  logic [31:0] brpc_m[2];
  logic        mflt[2];
  logic [31:0] mfpc[2];
  logic [31:0] mcnt[2];
  logic [31:0] mrf[2][32];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    riscv_issue_ctrl #(.FWD_EN(g == 0), .COUNT_W(32)) u_dut (
      .InClk(clk), .InRstN(rst_n),
      .InFetchValid(fv[g]), .InFetchOpcode(f_op[g]), .InFetchPc(f_pc[g]),
      .InFetchInvalid(finv[g]), .InFetchRdIdx(f_rd[g]), .InFetchRaIdx(f_ra[g]),
      .InFetchRbIdx(f_rb[g]), .OutFetchAccept(o_acc[g]), .OutFetchRedirect(o_red[g]),
      .OutFetchRedirectPc(o_redpc[g]), .InStall(stall[g]),
      .OutRfRaIdx(o_rfra[g]), .OutRfRbIdx(o_rfrb[g]),
      .InRfRaValue(rfa[g]), .InRfRbValue(rfb[g]),
      .OutRfWrEn(o_we[g]), .OutRfWrIdx(o_widx[g]), .OutRfWrData(o_wdat[g]),
      .OutExecValid(o_ev[g]), .OutExecOpcode(o_eop[g]), .OutExecPc(o_epc[g]),
      .OutExecInvalid(o_einv[g]), .OutExecRdIdx(o_erd[g]), .OutExecRaIdx(o_era[g]),
      .OutExecRbIdx(o_erb[g]), .OutExecRaOperand(o_opa[g]), .OutExecRbOperand(o_opb[g]),
      .OutExecHold(o_hold[g]), .InExecWbValue(wbv[g]),
      .InBranchRequest(brq[g]), .InBranchIsTaken(brt[g]), .InBranchPc(brpc[g]),
      .OutFault(o_flt[g]), .OutFaultPc(o_fpc[g]), .OutIssueCount(o_cnt[g])
    );
    assign rfa[g] = env_rf[g][o_rfra[g]];
    assign rfb[g] = env_rf[g][o_rfrb[g]];
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cyc %0d: got %h expected %h", nm, k, cyc_no, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input int k, input logic act, input logic exp);
    chk(nm, k, {31'd0, act}, {31'd0, exp});
  endtask

  // instruction encoders
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic is_ctrl(input logic [31:0] op);
    return (op[6:0] == 7'h6f) || (op[6:0] == 7'h67) || (op[6:0] == 7'h63);
  endfunction

  // behaviour of riscv_exec for the subset used here; branches produce 0 as their result
  function automatic void exec_fn(input logic [31:0] op, input logic [31:0] pc, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r, output logic tk,
                                  output logic [31:0] tgt);
    logic [31:0] ii, ib, ij;
    ii = {{20{op[31]}}, op[31:20]};
    ib = {{19{op[31]}}, op[31], op[7], op[30:25], op[11:8], 1'b0};
    ij = {{11{op[31]}}, op[31], op[19:12], op[20], op[30:21], 1'b0};
    r = 32'd0; tk = 1'b0; tgt = 32'd0;
    case (op[6:0])
      7'h13: r = a + ii;
      7'h33: r = a + b;
      7'h63: begin tk = (op[14:12] == 3'd1) ? (a != b) : (a == b); tgt = pc + ib; end
      7'h6f: begin r = pc + 32'd4; tk = 1'b1; tgt = pc + ij; end
      7'h67: begin r = pc + 32'd4; tk = 1'b1; tgt = (a + ii) & ~32'd1; end
      default: ;
    endcase
  endfunction

  // one model cycle: check what the DUT must show now, then advance past the coming edge
  task automatic model_step(input int k);
    ins_t h, nw;
    logic bv, wen, fa, fb, raws, iss, acc, red, fwd, tk;
    logic [31:0] oa, ob, r, tgt;
    fwd = (k == 0);
    if (!rst_n) begin
      mq[k].delete();
      ms[k] = 0; pv[k] = 0; prd[k] = 0; pval[k] = 0; brt_m[k] = 0; brpc_m[k] = 0;
      mflt[k] = 0; mfpc[k] = 0; mcnt[k] = 0;
      for (int i = 0; i < 32; i++) mrf[k][i] = 32'd0;
      chk1("rst_hold", k, o_hold[k], 1'b1);
      chk1("rst_accept", k, o_acc[k], 1'b0);
      chk1("rst_execvalid", k, o_ev[k], 1'b0);
      chk1("rst_rfwren", k, o_we[k], 1'b0);
      chk1("rst_redirect", k, o_red[k], 1'b0);
      chk1("rst_fault", k, o_flt[k], 1'b0);
      chk("rst_count", k, o_cnt[k], 32'd0);
      chk("rst_faultpc", k, o_fpc[k], 32'd0);
      chk("rst_execpc", k, o_epc[k], 32'd0);
      chk("rst_opa", k, o_opa[k], 32'd0);
      return;
    end
    bv   = mq[k].size() != 0;
    h    = bv ? mq[k][0] : '0;
    wen  = pv[k] && (prd[k] != 5'd0);
    fa   = wen && (h.ra == prd[k]);
    fb   = wen && (h.rb == prd[k]);
    raws = !fwd && (fa || fb);
    oa   = (fwd && fa) ? pval[k] : mrf[k][h.ra];
    ob   = (fwd && fb) ? pval[k] : mrf[k][h.rb];
    iss  = (ms[k] == 0) && bv && !h.inv && !stall[k] && !raws;
    acc  = (ms[k] == 0) && (!bv || iss);
    red  = (ms[k] == 1) && brt_m[k];

    chk1("exec_valid", k, o_ev[k], iss);
    chk1("exec_hold", k, o_hold[k], !iss);
    chk1("exec_invalid", k, o_einv[k], 1'b0);
    chk1("fetch_accept", k, o_acc[k], acc);
    chk1("rf_wren", k, o_we[k], wen);
    chk("rf_wrdata", k, o_wdat[k], pv[k] ? pval[k] : 32'd0);
    if (wen) chk("rf_wridx", k, {27'd0, o_widx[k]}, {27'd0, prd[k]});
    chk1("redirect", k, o_red[k], red);
    chk("redirect_pc", k, o_redpc[k], red ? brpc_m[k] : 32'd0);
    chk1("fault", k, o_flt[k], mflt[k]);
    chk("fault_pc", k, o_fpc[k], mfpc[k]);
    chk("issue_count", k, o_cnt[k], mcnt[k]);
    if (bv) chk("rf_ra_idx", k, {27'd0, o_rfra[k]}, {27'd0, h.ra});
    if (iss) begin
      chk("exec_pc", k, o_epc[k], h.pc);
      chk("exec_opcode", k, o_eop[k], h.op);
      chk("exec_rd", k, {27'd0, o_erd[k]}, {27'd0, h.rd});
      chk("operand_a", k, o_opa[k], oa);
      chk("operand_b", k, o_opb[k], ob);
    end

    if (wen) mrf[k][prd[k]] = pval[k];
    r = 32'd0; tk = 1'b0; tgt = 32'd0;
    if (iss) begin
      exec_fn(h.op, h.pc, oa, ob, r, tk, tgt);
      pv[k] = 1'b1; prd[k] = h.rd; pval[k] = r; mcnt[k] = mcnt[k] + 32'd1;
    end else begin
      pv[k] = 1'b0;
    end
    if (ms[k] == 0) begin
      if (bv && h.inv) begin
        ms[k] = 2; mflt[k] = 1'b1; mfpc[k] = h.pc;
      end else if (iss && is_ctrl(h.op)) begin
        ms[k] = 1; brt_m[k] = tk; brpc_m[k] = tgt;
      end
    end else if (ms[k] == 1) begin
      ms[k] = 0;
      if (brt_m[k]) mq[k].delete();
    end
    if (iss) void'(mq[k].pop_front());
    if (acc && fv[k]) begin
      nw.op = f_op[k]; nw.pc = f_pc[k]; nw.inv = finv[k];
      nw.rd = f_rd[k]; nw.ra = f_ra[k]; nw.rb = f_rb[k];
      mq[k].push_back(nw);
    end
  endtask

  task automatic drive_fetch(input int k);
    logic [31:0] pc, w;
    logic inr;
    pc  = fetch_pc[k];
    inr = (pc >= prog_lo) && (pc < prog_hi);
    w   = mem[pc[9:2]];
    fv[k]   = inr && ($urandom_range(99) < vpct);
    f_op[k] = w;
    f_pc[k] = pc;
    finv[k] = minv[pc[9:2]];
    f_rd[k] = w[11:7];
    f_ra[k] = w[19:15];
    f_rb[k] = w[24:20];
    if (smode == 1)      stall[k] = ($urandom_range(99) < 20);
    else if (smode == 2) stall[k] = (n_iss[k] >= 1);
    else                 stall[k] = 1'b0;
  endtask

  task automatic cyc();
    logic s_take[2], s_red[2], s_we[2], s_ev[2], tk;
    logic [31:0] s_redpc[2], s_wdat[2], s_eop[2], s_epc[2], s_opa[2], s_opb[2], r, tgt;
    logic [4:0] s_widx[2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      s_take[k] = o_acc[k] & fv[k];
      s_red[k] = o_red[k]; s_redpc[k] = o_redpc[k];
      s_we[k] = o_we[k]; s_widx[k] = o_widx[k]; s_wdat[k] = o_wdat[k];
      s_ev[k] = o_ev[k]; s_eop[k] = o_eop[k]; s_epc[k] = o_epc[k];
      s_opa[k] = o_opa[k]; s_opb[k] = o_opb[k];
    end
    @(posedge clk);
    #1;
    cyc_no++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        fetch_pc[k] = start_pc;
        wbv[k] = 0; brq[k] = 0; brt[k] = 0; brpc[k] = 0;
        for (int i = 0; i < 32; i++) env_rf[k][i] = 32'd0;
        n_iss[k] = 0; n_red[k] = 0; red_pc[k] = 0;
      end else begin
        if (s_we[k] && s_widx[k] != 5'd0) env_rf[k][s_widx[k]] = s_wdat[k];
        if (s_ev[k]) begin
          exec_fn(s_eop[k], s_epc[k], s_opa[k], s_opb[k], r, tk, tgt);
          wbv[k] = r; brq[k] = is_ctrl(s_eop[k]); brt[k] = tk; brpc[k] = tgt;
          if (n_iss[k] < 8) begin
            c_iss[k][n_iss[k]] = cyc_no; p_iss[k][n_iss[k]] = s_epc[k];
          end
          n_iss[k]++;
        end
        if (s_red[k]) begin
          fetch_pc[k] = s_redpc[k]; n_red[k]++; red_pc[k] = s_redpc[k];
        end else if (s_take[k]) begin
          fetch_pc[k] = fetch_pc[k] + 32'd4;
        end
      end
      drive_fetch(k);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin mem[i] = 32'h13; minv[i] = 1'b0; end
  endtask

  task automatic put(input logic [31:0] pc, input logic [31:0] w, input logic inv);
    mem[pc[9:2]] = w; minv[pc[9:2]] = inv;
  endtask

  task automatic run_phase(input logic [31:0] lo, input logic [31:0] hi, input int sm, input int vp, input int n);
    prog_lo = lo; prog_hi = hi; start_pc = lo; smode = sm; vpct = vp;
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (n) cyc();
  endtask

  task automatic gen_rand(input int n, input int inv_at);
    logic [31:0] w;
    logic [4:0] a, b, d;
    clear_mem();
    for (int i = 0; i < n; i++) begin
      a = 5'($urandom_range(7)); b = 5'($urandom_range(7)); d = 5'($urandom_range(1, 7));
      case ($urandom_range(5))
        0, 1:    w = enc_i(12'($urandom_range(63)), a, d);
        2, 3:    w = enc_r(b, a, d);
        4:       w = enc_b(13'(4 * $urandom_range(1, 4)), b, a, 3'($urandom_range(1)));
        default: w = enc_j(21'(4 * $urandom_range(1, 3)), 5'($urandom_range(3)));
      endcase
      mem[i] = w; minv[i] = (i == inv_at);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      fv[k] = 0; finv[k] = 0; stall[k] = 0; f_op[k] = 0; f_pc[k] = 0;
      f_rd[k] = 0; f_ra[k] = 0; f_rb[k] = 0; wbv[k] = 0; brq[k] = 0; brt[k] = 0; brpc[k] = 0;
      fetch_pc[k] = 0; n_iss[k] = 0; n_red[k] = 0; red_pc[k] = 0;
      for (int i = 0; i < 32; i++) env_rf[k][i] = 32'd0;
    end
    clear_mem();

    // addi x1,x0,5 ; add x2,x1,x1
    put(32'h0, enc_i(12'd5, 5'd0, 5'd1), 1'b0);
    put(32'h4, enc_r(5'd1, 5'd1, 5'd2), 1'b0);
    run_phase(32'h0, 32'h8, 0, 100, 12);
    for (int k = 0; k < 2; k++) begin
      chk("p1_x1", k, env_rf[k][1], 32'd5);
      chk("p1_x2", k, env_rf[k][2], 32'd10);
      chk("p1_count", k, o_cnt[k], 32'd2);
      chk("p1_issue_gap", k, c_iss[k][1] - c_iss[k][0], (k == 0) ? 32'd1 : 32'd2);
    end

    // beq x0,x0,+16 at 0x100, wrong path at 0x104..0x10c
    clear_mem();
    put(32'h100, enc_b(13'd16, 5'd0, 5'd0, 3'd0), 1'b0);
    put(32'h104, enc_i(12'd1, 5'd0, 5'd3), 1'b0);
    put(32'h108, enc_i(12'd2, 5'd0, 5'd3), 1'b0);
    put(32'h10c, enc_i(12'd3, 5'd0, 5'd3), 1'b0);
    put(32'h110, enc_i(12'd7, 5'd0, 5'd4), 1'b0);
    run_phase(32'h100, 32'h114, 0, 100, 12);
    for (int k = 0; k < 2; k++) begin
      chk("p2_redirects", k, n_red[k], 32'd1);
      chk("p2_redirect_pc", k, red_pc[k], 32'h110);
      chk("p2_second_pc", k, p_iss[k][1], 32'h110);
      chk("p2_x3", k, env_rf[k][3], 32'd0);
      chk("p2_x4", k, env_rf[k][4], 32'd7);
    end

    // bne x0,x0,+8 at 0x200 falls through
    clear_mem();
    put(32'h200, enc_b(13'd8, 5'd0, 5'd0, 3'd1), 1'b0);
    put(32'h204, enc_i(12'd9, 5'd0, 5'd5), 1'b0);
    run_phase(32'h200, 32'h208, 0, 10, 0);
    vpct = 100;
    repeat (12) cyc();
    for (int k = 0; k < 2; k++) begin
      chk("p3_redirects", k, n_red[k], 32'd0);
      chk("p3_second_pc", k, p_iss[k][1], 32'h204);
      chk("p3_issue_gap", k, c_iss[k][1] - c_iss[k][0], 32'd2);
      chk("p3_x5", k, env_rf[k][5], 32'd9);
    end

    // jal x1,+0x40 at 0x300
    clear_mem();
    for (int a = 32'h304; a < 32'h340; a += 4) put(a, enc_i(12'd1, 5'd0, 5'd6), 1'b0);
    put(32'h300, enc_j(21'h40, 5'd1), 1'b0);
    put(32'h340, enc_i(12'd2, 5'd0, 5'd6), 1'b0);
    run_phase(32'h300, 32'h344, 0, 100, 12);
    for (int k = 0; k < 2; k++) begin
      chk("p4_link", k, env_rf[k][1], 32'h304);
      chk("p4_redirect_pc", k, red_pc[k], 32'h340);
      chk("p4_second_pc", k, p_iss[k][1], 32'h340);
      chk("p4_x6", k, env_rf[k][6], 32'd2);
    end

    // addi at 0x3fc then an illegal instruction at 0x400 under stall
    clear_mem();
    put(32'h3fc, enc_i(12'd3, 5'd0, 5'd7), 1'b0);
    put(32'h400, 32'hffff_ffff, 1'b1);
    put(32'h404, enc_i(12'd4, 5'd0, 5'd8), 1'b0);
    run_phase(32'h3fc, 32'h408, 2, 100, 10);
    for (int k = 0; k < 2; k++) begin
      chk("p5_x7", k, env_rf[k][7], 32'd3);
      chk("p5_x8", k, env_rf[k][8], 32'd0);
      chk1("p5_fault", k, o_flt[k], 1'b1);
      chk("p5_fault_pc", k, o_fpc[k], 32'h400);
      chk1("p5_accept", k, o_acc[k], 1'b0);
      chk("p5_count", k, o_cnt[k], 32'd1);
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk1("p5_rst_fault", k, o_flt[k], 1'b0);
      chk("p5_rst_fault_pc", k, o_fpc[k], 32'd0);
      chk("p5_rst_count", k, o_cnt[k], 32'd0);
      chk1("p5_rst_hold", k, o_hold[k], 1'b1);
    end

    // randomized programs with fetch gaps and random stalls
    for (int rnd = 0; rnd < 4; rnd++) begin
      gen_rand(48, (rnd == 3) ? int'($urandom_range(20, 40)) : -1);
      run_phase(32'h800, 32'h800 + 32'd192, 1, 75, 250);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_issue_ctrl.md
Name: riscv_issue_ctrl

Overview:
- Issue/sequencing controller in front of riscv_exec.
- Buffers one decoded instruction from fetch/decode, reads register-file operands, and resolves RAW hazards against the in-flight result by forwarding or stalling.
- Drives riscv_exec's opcode inputs and hold, writes its registered result back to the register file, and turns its registered branch outcome into a fetch redirect and flush.
- Latches illegal-instruction faults.

Parameters:
FWD_EN, 1, 1 = forward InExecWbValue to a dependent next instruction; 0 = insert one stall cycle instead
COUNT_W, 32, width of issued-instruction counter

Ports:
InClk  in  1  clock
InRstN  in  1  reset, asynchronous, active-low
InFetchValid  in  1  decoded instruction offered
InFetchOpcode  in  32  instruction word
InFetchPc  in  32  instruction PC
InFetchInvalid  in  1  decoder flagged illegal
InFetchRdIdx/InFetchRaIdx/InFetchRbIdx  in  5 each  register indices
OutFetchAccept  out  1  instruction taken this cycle (valid&accept)
OutFetchRedirect  out  1  one-cycle pulse: flush fetch, restart at OutFetchRedirectPc
OutFetchRedirectPc  out  32  redirect target
InStall  in  1  external stall: no new issue
OutRfRaIdx/OutRfRbIdx  out  5 each  register-file read indices (combinational read)
InRfRaValue/InRfRbValue  in  32 each  register-file read data
OutRfWrEn  out  1  register-file write strobe
OutRfWrIdx  out  5  write index
OutRfWrData  out  32  write data
OutExecValid  out  1  to exec InOpcodeValid
OutExecOpcode/OutExecPc  out  32 each  to exec
OutExecInvalid  out  1  tied 0 (faults never issued)
OutExecRdIdx/OutExecRaIdx/OutExecRbIdx  out  5 each  to exec
OutExecRaOperand/OutExecRbOperand  out  32 each  to exec, post-forwarding
OutExecHold  out  1  to exec InHold
InExecWbValue  in  32  exec OutWritebackValue
InBranchRequest/InBranchIsTaken  in  1 each  exec registered branch outcome
InBranchPc  in  32  exec OutBranchPc
OutFault  out  1  sticky illegal-instruction flag
OutFaultPc  out  32  PC of faulting instruction
OutIssueCount  out  COUNT_W  instructions issued, wraps

Behaviour:
- Reset (InRstN=0, async): state RUN, buffer empty, pending writeback cleared. Every output 0 except OutExecHold=1. Counter=0. Reset mid-branch or mid-fault discards everything.
- Buffer, 1 entry: OutFetchAccept = state==RUN & (~BufValid | Issue). On accept, load opcode/pc/idx/invalid.
- Exec/RF drive: Exec opcode, PC and idx outputs and RF read idx come combinationally from the buffer.
- Issue = state==RUN & BufValid & ~BufInvalid & ~InStall & ~RawStall.
  - OutExecValid = Issue; OutExecHold = ~Issue.
  - Result appears on InExecWbValue exactly one cycle later.
- Pending writeback register: at an Issue edge, PendValid<=1, PendRd<=BufRd; otherwise PendValid<=0.
- Writeback: in the cycle after issue, OutRfWrEn = PendValid & PendRd!=0, OutRfWrIdx=PendRd, OutRfWrData=InExecWbValue.
  - Writeback is never blocked by InStall.
  - Writeback is not suppressed for branches: the jal/jalr link is written; for beq..bgeu, rd is the imm field and is written harmlessly. Writeback is always performed.
- Hazard: Dep = PendValid & PendRd!=0 & (BufRa==PendRd | BufRb==PendRd).
  - FWD_EN=1: each matching operand selects InExecWbValue instead of RF data; RawStall=0.
  - FWD_EN=0: RawStall=Dep, giving one bubble; RF data is read after the write.
  - Index 0 is never forwarded.
- Control instructions (opcode[6:0] = 1101111, 1100111, 1100011): on issue, next state BR_WAIT for exactly one cycle.
  - In BR_WAIT: no issue, OutFetchAccept=0.
  - Branch outputs are sampled in BR_WAIT regardless of InStall.
  - If InBranchRequest & InBranchIsTaken: OutFetchRedirect=1, OutFetchRedirectPc=InBranchPc, BufValid<=0 (wrong-path drop).
  - Not taken: the buffer is kept.
  - Either way, return to RUN.
- Branch outputs are ignored outside BR_WAIT; exec holds stale values when not valid.
- Fault: in RUN with BufValid & BufInvalid (InStall ignored), next state FAULT.
  - OutFault<=1, OutFaultPc<=BufPc.
  - Nothing issued; accept=0 until reset.
  - The pending writeback of the prior instruction still completes.
- OutIssueCount increments on every Issue and wraps at 2^COUNT_W.
- States: RUN -> BR_WAIT on issue of a control instruction; BR_WAIT -> RUN always; RUN -> FAULT on invalid at head; FAULT terminal.

Test Plan:
- addi x1,x0,5 then add x2,x1,x1 back-to-back, FWD_EN=1:
  - Issue on consecutive cycles; Ra=Rb operand=5.
  - RF writes x1=5, then x2=10. Counter=2.
- Same sequence, FWD_EN=0: one bubble between issues (OutExecHold=1 for that cycle); x2=10.
- beq x0,x0,+16 at PC 0x100 with next instruction buffered:
  - BR_WAIT cycle: OutFetchRedirect pulse with Pc=0x110.
  - Buffer flushed; next issued PC = 0x110.
- bne x0,x0 at 0x200: no redirect; buffered 0x204 issues the cycle after BR_WAIT.
- jal x1,+0x40 at 0x300: writeback x1=0x304, redirect to 0x340.
- Invalid instruction at 0x400 with InStall=1 after a prior addi:
  - addi writeback still occurs.
  - OutFault=1, OutFaultPc=0x400, no further accept.
  - Asserting InRstN=0 clears all.
